// File: rtl/edp_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : edp_muldiv_seq
//  Purpose  : Step sequencer for the EDP multiply/divide inner loop. Drives
//             the AD function select, AR load and MQ shift/load controls for
//             shift-add multiply and non-restoring divide, including the
//             no-divide check on the trial subtract.
//  Revision : 1.0  initial release
// ============================================================================
module edp_muldiv_seq #(
    parameter int STEPS = 36,
    parameter int CW    = 6
) (
    input  logic          clk_edp_h,
    input  logic          reset_h,
    input  logic          start_h,
    input  logic          div_h,
    input  logic          abort_h,
    input  logic          mq_35_h,
    input  logic          ad_00_h,
    output logic          busy_h,
    output logic          done_h,
    output logic          ndv_h,
    output logic [1:0]    ad_op,
    output logic          ar_load_h,
    output logic [1:0]    mq_sel,
    output logic [CW-1:0] step_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TRIAL = 3'd2,
        S_STEP  = 3'd3,
        S_FIXUP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // AD function select encodings (2'b11 is reserved and never issued)
    localparam logic [1:0] c_ad_pass = 2'b00;
    localparam logic [1:0] c_ad_add  = 2'b01;
    localparam logic [1:0] c_ad_sub  = 2'b10;

    // MQ control encodings
    localparam logic [1:0] c_mq_hold = 2'b00;
    localparam logic [1:0] c_mq_load = 2'b01;
    localparam logic [1:0] c_mq_shr  = 2'b10;
    localparam logic [1:0] c_mq_shl  = 2'b11;

    localparam logic [CW-1:0] c_steps = CW'(STEPS);
    localparam logic [CW-1:0] c_one   = CW'(1);

    state_t        r_state;
    logic          r_op_div;
    logic          r_neg;
    logic          r_ndv;
    logic [CW-1:0] r_cnt;

    // Sequencer state, step counter and the divide sign / no-divide flags
    always_ff @(posedge clk_edp_h or posedge reset_h) begin
        if (reset_h) begin
            r_state  <= S_IDLE;
            r_op_div <= 1'b0;
            r_neg    <= 1'b0;
            r_ndv    <= 1'b0;
            r_cnt    <= '0;
        end else if (abort_h) begin
            // Abort wins over every transition; the no-divide flag is kept
            r_state  <= S_IDLE;
            r_op_div <= 1'b0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_h) begin
                        r_op_div <= div_h;
                        r_ndv    <= 1'b0;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= c_steps;
                    r_state <= r_op_div ? S_TRIAL : S_STEP;
                end
                S_TRIAL: begin
                    // A non-negative trial remainder means the quotient overflows
                    if (!ad_00_h) begin
                        r_ndv   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_neg   <= 1'b1;
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_one;
                    end
                    if (r_op_div) begin
                        r_neg <= ad_00_h;
                    end
                    // Treating a zero count as last guards against a stuck loop
                    if (r_cnt <= c_one) begin
                        r_state <= r_op_div ? S_FIXUP : S_DONE;
                    end
                end
                S_FIXUP: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Slice controls decoded from the registered state; only the STEP-cycle
    // AD select looks at the live multiplier bit
    always_comb begin
        busy_h    = 1'b0;
        done_h    = 1'b0;
        ad_op     = c_ad_pass;
        ar_load_h = 1'b0;
        mq_sel    = c_mq_hold;
        case (r_state)
            S_IDLE: begin
                busy_h = 1'b0;
            end
            S_LOAD: begin
                busy_h = 1'b1;
                mq_sel = c_mq_load;
            end
            S_TRIAL: begin
                busy_h    = 1'b1;
                ad_op     = c_ad_sub;
                ar_load_h = 1'b1;
            end
            S_STEP: begin
                busy_h    = 1'b1;
                ar_load_h = 1'b1;
                if (r_op_div) begin
                    ad_op  = r_neg ? c_ad_add : c_ad_sub;
                    mq_sel = c_mq_shl;
                end else begin
                    ad_op  = mq_35_h ? c_ad_add : c_ad_pass;
                    mq_sel = c_mq_shr;
                end
            end
            S_FIXUP: begin
                // Restore a negative final remainder by adding the divisor back
                busy_h    = 1'b1;
                ad_op     = r_neg ? c_ad_add : c_ad_pass;
                ar_load_h = r_neg;
            end
            S_DONE: begin
                busy_h = 1'b1;
                done_h = 1'b1;
            end
            default: begin
                busy_h = 1'b0;
            end
        endcase
    end

    assign ndv_h    = r_ndv;
    assign step_cnt = r_cnt;

endmodule
`default_nettype wire
